z_streamer: RTL and testbench

Z_STREAMER -- requirements
Module: z_streamer

---
 rtl/matmul_pkg.sv | 21 ++
 rtl/z_stream_fifo.sv | 67 ++++++
 rtl/z_streamer.sv | 170 +++++++++++++++++
 tb/tb_z_streamer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply result path.
// Holds the result-streamer state encoding, default data/address widths
// and the output FIFO geometry used by z_streamer and z_stream_fifo.
package matmul_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 10;
   localparam int unsigned DEF_NUM_WORDS  = 1024;

   // Output FIFO geometry: two entries cover the one-cycle memory latency
   // while still sustaining one word per cycle.
   localparam int unsigned FIFO_DEPTH     = 2;
   localparam int unsigned FIFO_CNT_WIDTH = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } z_state_e;

endpackage : matmul_pkg

// File: rtl/z_stream_fifo.sv
// Two-entry output FIFO for the result streamer.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   push, push_data   - write one entry (ignored when full without a pop)
//   pop               - remove the head entry (ignored when empty)
//   head              - current head entry (registered storage)
//   count             - number of valid entries (0..2)
module z_stream_fifo
   import matmul_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_DATA_WIDTH + 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop,
   output logic [WIDTH-1:0]          head,
   output logic [FIFO_CNT_WIDTH-1:0] count
);

   logic [WIDTH-1:0]          entry_q [FIFO_DEPTH];
   logic [WIDTH-1:0]          entry_d [FIFO_DEPTH];
   logic                      rd_ptr_q, rd_ptr_d;
   logic                      wr_ptr_q, wr_ptr_d;
   logic [FIFO_CNT_WIDTH-1:0] count_q, count_d;
   logic                      do_push, do_pop;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      entry_d  = entry_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      do_pop   = pop && (count_q != '0);
      // A push into a full FIFO is only legal when the head leaves this cycle.
      do_push  = push && ((count_q != FIFO_CNT_WIDTH'(FIFO_DEPTH)) || do_pop);
      if (do_push) begin
         entry_d[wr_ptr_q] = push_data;
         wr_ptr_d          = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + FIFO_CNT_WIDTH'(do_push) - FIFO_CNT_WIDTH'(do_pop);
   end

   // Storage and pointer registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         entry_q  <= entry_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = entry_q[rd_ptr_q];
   assign count = count_q;

endmodule : z_stream_fifo

// File: rtl/z_streamer.sv
// Streams the result matrix out of the Z memory as a valid/ready word stream.
// On start, reads addresses 0..NUM_WORDS-1 (1-cycle read latency) into a
// two-entry FIFO and presents them on out_*; out_last marks the final word
// and done pulses the cycle after it is accepted.
// Optional clear-on-read: define Z_STREAMER_CLEAR_EN to zero each word on the
// memory's second port in the cycle it is captured; otherwise z_clr_* are 0.
// Ports:
//   clock, reset                        - clock, synchronous active-high reset
//   start / busy / done                 - launch, activity flag, completion pulse
//   z_addr, z_rd_en, z_dout             - read port of the result memory
//   z_clr_addr, z_clr_din, z_clr_wr_en  - write port used for clearing
//   out_data, out_valid, out_ready, out_last - output stream
module z_streamer
   import matmul_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] z_addr,
   output logic                  z_rd_en,
   input  logic [DATA_WIDTH-1:0] z_dout,
   output logic [ADDR_WIDTH-1:0] z_clr_addr,
   output logic [DATA_WIDTH-1:0] z_clr_din,
   output logic                  z_clr_wr_en,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int unsigned           FIFO_W    = DATA_WIDTH + 1;
   localparam int unsigned           CRED_W    = 3;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   z_state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic                      cap_q, cap_d;
   logic                      cap_last_q, cap_last_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      issue_c;
   logic                      pop_c;
   logic [CRED_W-1:0]         credit_c;
   logic [FIFO_CNT_WIDTH-1:0] fifo_count;
   logic [FIFO_W-1:0]         fifo_head;

   assign out_valid = (fifo_count != '0);
   assign pop_c     = out_valid && out_ready;

   // Sequencer: issue reads while the FIFO plus in-flight word leaves room.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cap_d      = 1'b0;
      cap_last_d = 1'b0;
      done_d     = 1'b0;
      issue_c    = 1'b0;
      // Occupancy this FIFO will have once the in-flight word lands and the
      // head (if accepted now) leaves.
      credit_c   = CRED_W'(fifo_count) + CRED_W'(cap_q) - CRED_W'(pop_c);
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = STREAM;
               addr_d  = '0;
            end
         end
         STREAM: begin
            if (credit_c < CRED_W'(FIFO_DEPTH)) begin
               issue_c    = 1'b1;
               cap_d      = 1'b1;
               cap_last_d = (addr_q == LAST_ADDR);
               // Address saturates at the last word; the FSM leaves STREAM.
               if (addr_q == LAST_ADDR) begin
                  state_d = DRAIN;
               end else begin
                  addr_d = addr_q + ADDR_WIDTH'(1);
               end
            end
         end
         DRAIN: begin
            if (pop_c && out_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
               addr_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Control registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         cap_q      <= 1'b0;
         cap_last_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cap_q      <= cap_d;
         cap_last_q <= cap_last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Read strobe is suppressed during reset so an aborted stream stops at once.
   assign z_rd_en = issue_c && !reset;
   assign z_addr  = addr_q;
   assign busy    = busy_q;
   assign done    = done_q;

   // Output FIFO carries {last, data}.
   z_stream_fifo #(
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (cap_q),
      .push_data ({cap_last_q, z_dout}),
      .pop       (pop_c),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign out_last = fifo_head[FIFO_W-1];
   assign out_data = fifo_head[DATA_WIDTH-1:0];

`ifdef Z_STREAMER_CLEAR_EN
   logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;

   // Address of the word being captured, reused as the clear address.
   always_comb begin
      cap_addr_d = cap_addr_q;
      if (issue_c) begin
         cap_addr_d = addr_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cap_addr_q <= '0;
      end else begin
         cap_addr_q <= cap_addr_d;
      end
   end

   assign z_clr_wr_en = cap_q && !reset;
   assign z_clr_addr  = cap_addr_q;
   assign z_clr_din   = '0;
`else
   assign z_clr_wr_en = 1'b0;
   assign z_clr_addr  = '0;
   assign z_clr_din   = '0;
`endif

endmodule : z_streamer

// File: tb/tb_z_streamer.sv
// Directed bench for z_streamer: a 4-word instance and a 1-word instance,
// each with a 1-cycle-latency dual-port memory model. Expected words are
// queued when a stream is launched and popped on every accepted transfer.
module tb_z_streamer;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 10;

   logic          clock = 1'b0;
   logic          reset;
   always #5 clock = ~clock;

   // 4-word instance
   logic          start, busy, done, z_rd_en, clr_wr_en, out_valid, out_ready, out_last;
   logic [AW-1:0] z_addr, clr_addr;
   logic [DW-1:0] z_dout, clr_din, out_data;
   // 1-word instance
   logic          start1, busy1, done1, z_rd_en1, clr_wr_en1, out_valid1, out_ready1, out_last1;
   logic [AW-1:0] z_addr1, clr_addr1;
   logic [DW-1:0] z_dout1, clr_din1, out_data1;

   z_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(4)) u_dut (
      .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
      .z_addr(z_addr), .z_rd_en(z_rd_en), .z_dout(z_dout),
      .z_clr_addr(clr_addr), .z_clr_din(clr_din), .z_clr_wr_en(clr_wr_en),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   z_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(1)) u_dut1 (
      .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
      .z_addr(z_addr1), .z_rd_en(z_rd_en1), .z_dout(z_dout1),
      .z_clr_addr(clr_addr1), .z_clr_din(clr_din1), .z_clr_wr_en(clr_wr_en1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1)
   );

   // Memory models with a bench-side load port.
   logic [DW-1:0] mem4 [4];
   logic [DW-1:0] mem1;
   logic          ld_en, ld_sel;
   logic [1:0]    ld_addr;
   logic [DW-1:0] ld_data;

   always @(posedge clock) begin
      if (ld_en && !ld_sel) mem4[ld_addr] <= ld_data;
      else if (clr_wr_en) mem4[clr_addr[1:0]] <= clr_din;
      if (ld_en && ld_sel) mem1 <= ld_data;
      else if (clr_wr_en1) mem1 <= clr_din1;
      if (z_rd_en) z_dout <= mem4[z_addr[1:0]];
      if (z_rd_en1) z_dout1 <= mem1;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [DW-1:0] vals [4];
   logic [DW-1:0] shadow [4];
   logic [32:0]   sb [$];

   // Queue the words the next stream should deliver; clear-on-read empties them.
   task automatic push_stream();
      for (int i = 0; i < 4; i++) begin
         sb.push_back({(i == 3), shadow[i]});
`ifdef Z_STREAMER_CLEAR_EN
         shadow[i] = '0;
`endif
      end
   endtask

   task automatic load4();
      for (int i = 0; i < 4; i++) begin
         ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 2'(i); ld_data = vals[i];
         shadow[i] = vals[i];
         tick();
      end
      ld_en = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 64'(done), 64'd1);
   endtask

   // Transfer / read-order / hold / clear monitor for the 4-word instance.
   int            issued, xfer, exp_addr, rd1_cnt;
   logic          prev_valid, prev_ready, prev_last, prev_rd;
   logic [DW-1:0] prev_data;
   logic [AW-1:0] prev_addr;
   logic [32:0]   exp_w;

   always @(negedge clock) begin
      if (reset) begin
         issued = 0; xfer = 0; exp_addr = 0;
         prev_valid = 1'b0; prev_ready = 1'b0; prev_rd = 1'b0;
      end else begin
         if (z_rd_en) begin
            chk("rd_addr", 64'(z_addr), 64'(exp_addr));
            exp_addr++;
            issued++;
         end
         if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               exp_w = sb.pop_front();
               chk("xfer_word", 64'({out_last, out_data}), 64'(exp_w));
            end
            xfer++;
         end
         chk("outstanding_le2", 64'((issued - xfer) <= 2), 64'd1);
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(prev_data));
            chk("hold_last", 64'(out_last), 64'(prev_last));
         end
`ifdef Z_STREAMER_CLEAR_EN
         chk("clr_wr_en", 64'(clr_wr_en), 64'(prev_rd));
         if (prev_rd) begin
            chk("clr_addr", 64'(clr_addr), 64'(prev_addr));
            chk("clr_din", 64'(clr_din), 64'd0);
         end
`else
         chk("clr_tied", {clr_wr_en, clr_addr, clr_din}, 64'd0);
`endif
         if (done) exp_addr = 0;
         prev_valid = out_valid; prev_ready = out_ready;
         prev_data  = out_data;  prev_last  = out_last;
         prev_rd    = z_rd_en;   prev_addr  = z_addr;
      end
   end

   // Read counter / address check for the 1-word instance.
   always @(negedge clock) begin
      if (reset) rd1_cnt = 0;
      else begin
         if (z_rd_en1) begin
            rd1_cnt++;
            chk("rd1_addr", 64'(z_addr1), 64'd0);
         end
         if (clr_wr_en1) chk("clr1_addr", 64'(clr_addr1), 64'd0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int x0;
      vals[0] = 32'd5; vals[1] = 32'hFFFF_FFFD; vals[2] = 32'd7; vals[3] = 32'd9;
      reset = 1'b1; start = 1'b0; start1 = 1'b0; out_ready = 1'b1; out_ready1 = 1'b1;
      ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
      tick(); tick();

      // Reset values
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_out_last", 64'(out_last), 0);
      chk("rst_out_data", 64'(out_data), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_rd_en", 64'(z_rd_en), 0);
      chk("rst_addr", 64'(z_addr), 0);
      chk("rst_clr_wr_en", 64'(clr_wr_en), 0);
      chk("rst_clr_addr", 64'(clr_addr), 0);
      chk("rst_clr_din", 64'(clr_din), 0);

      load4();
      ld_en = 1'b1; ld_sel = 1'b1; ld_addr = '0; ld_data = 32'd42;
      tick();
      ld_en = 1'b0;
      reset = 1'b0;
      tick();

      // Full-rate stream
      push_stream();
      start = 1'b1; tick(); start = 1'b0;
      chk("t1_busy", 64'(busy), 1);
      chk("t1_valid_e0", 64'(out_valid), 0);
      tick();
      chk("t1_valid_e1", 64'(out_valid), 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t1_valid", 64'(out_valid), 1);
         chk("t1_data", 64'(out_data), 64'(vals[i]));
         chk("t1_last", 64'(out_last), 64'(i == 3));
         tick();
      end
      chk("t1_done", 64'(done), 1);
      chk("t1_busy_end", 64'(busy), 0);
      chk("t1_valid_end", 64'(out_valid), 0);
      tick();
      chk("t1_done_pulse", 64'(done), 0);
      for (int i = 0; i < 4; i++) begin
`ifdef Z_STREAMER_CLEAR_EN
         chk("t1_mem_cleared", 64'(mem4[i]), 0);
`else
         chk("t1_mem_kept", 64'(mem4[i]), 64'(vals[i]));
`endif
      end

      // Backpressure on the first word, then start in the done cycle
      load4();
      push_stream();
      x0 = xfer;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_hold_valid", 64'(out_valid), 1);
         chk("t2_hold_data", 64'(out_data), 64'(vals[0]));
         tick();
      end
      out_ready = 1'b1;
      wait_done("t2_done");
      chk("t2_words", 64'(xfer - x0), 4);
      chk("t2_sb_empty", 64'(sb.size()), 0);
      push_stream();
      x0 = xfer;
      start = 1'b1; tick(); start = 1'b0;
      chk("t6_restart_busy", 64'(busy), 1);
      wait_done("t6_done");
      chk("t6_words", 64'(xfer - x0), 4);
      chk("t6_sb_empty", 64'(sb.size()), 0);
      tick();

      // Start pulsed mid-stream is ignored
      load4();
      push_stream();
      x0 = xfer;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_done("t3_done");
      chk("t3_words", 64'(xfer - x0), 4);
      tick(); tick(); tick();
      chk("t3_idle_busy", 64'(busy), 0);
      chk("t3_idle_valid", 64'(out_valid), 0);
      chk("t3_words_after", 64'(xfer - x0), 4);
      chk("t3_sb_empty", 64'(sb.size()), 0);

      // Reset after the second transfer
      load4();
      push_stream();
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick(); tick();
      reset = 1'b1; out_ready = 1'b0;
      sb.delete();
      tick();
      chk("t4_rst_valid", 64'(out_valid), 0);
      chk("t4_rst_rd_en", 64'(z_rd_en), 0);
      chk("t4_rst_busy", 64'(busy), 0);
      reset = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_no_read", 64'(z_rd_en), 0);
         chk("t4_no_valid", 64'(out_valid), 0);
      end
      load4();
      push_stream();
      x0 = xfer;
      start = 1'b1; tick(); start = 1'b0;
      wait_done("t4_done");
      chk("t4_words", 64'(xfer - x0), 4);
      chk("t4_sb_empty", 64'(sb.size()), 0);
      tick();

      // Single-word instance
      start1 = 1'b1; tick(); start1 = 1'b0;
      chk("t5_busy", 64'(busy1), 1);
      tick();
      chk("t5_valid_e1", 64'(out_valid1), 0);
      tick();
      chk("t5_valid", 64'(out_valid1), 1);
      chk("t5_data", 64'(out_data1), 42);
      chk("t5_last", 64'(out_last1), 1);
      tick();
      chk("t5_done", 64'(done1), 1);
      chk("t5_valid_end", 64'(out_valid1), 0);
      tick();
      chk("t5_done_pulse", 64'(done1), 0);
      chk("t5_reads", 64'(rd1_cnt), 1);
`ifdef Z_STREAMER_CLEAR_EN
      chk("t5_mem_cleared", 64'(mem1), 0);
`else
      chk("t5_mem_kept", 64'(mem1), 42);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_z_streamer
